// File: rtl/multiplicador_seq.sv
// Sequential shift-and-add multiply-accumulate: P = A*B + R (unsigned).
// One multiplier bit is consumed per clock. Start is accepted in IDLE or in
// the single DONE cycle, so operations can run back to back with one result
// every WIDTH+1 cycles.
//
// Handshake: start is sampled on each rising clk edge and only takes effect
// while busy is low (IDLE or DONE). busy is high for exactly WIDTH cycles
// per operation. done is a one-cycle pulse in the cycle after the last
// iteration, and busy and done are never high together. P and zero change
// only at a completion edge or at reset.
module multiplicador_seq #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   input  logic [WIDTH-1:0]     R,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   P,
   output logic                 zero
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state;
   state_t               state_next;

   logic [2*WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]     mplier;
   logic [2*WIDTH-1:0]   acc;
   logic [CW-1:0]        count;

   logic                 load;
   logic                 last_iter;
   logic [2*WIDTH-1:0]   acc_sum;

   // Accept a new operation only when not busy; detect the final iteration.
   always_comb begin
      load      = 1'b0;
      last_iter = 1'b0;
      if (start && (state == IDLE || state == DONE))
         load = 1'b1;
      if (state == RUN && count == LAST)
         last_iter = 1'b1;
   end

   // Conditional add of the shifted multiplicand; wraps modulo 2^(2*WIDTH).
   always_comb begin
      acc_sum = acc;
      if (mplier[0])
         acc_sum = acc + mcand;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last_iter) state_next = DONE;
         DONE:    state_next = start ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register with registered busy/done flags derived from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= (state_next == RUN);
         done  <= (state_next == DONE);
      end
   end

   // Datapath: capture operands on load, iterate in RUN, publish result on the last iteration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         count  <= '0;
         P      <= '0;
         zero   <= 1'b1;
      end else if (load) begin
         mcand  <= {{WIDTH{1'b0}}, A};
         mplier <= B;
         acc    <= {{WIDTH{1'b0}}, R};
         count  <= '0;
      end else if (state == RUN) begin
         acc    <= acc_sum;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count + 1'b1;
         if (last_iter) begin
            P    <= acc_sum;
            zero <= (acc_sum == '0);
         end
      end
   end

endmodule
